// File: rtl/bs_arbtr_rr_bcast.sv
// Shared-bus arbiter: moves one packet at a time from a driver FIFO head
// to one receiver (unicast) or to every receiver except the source
// (broadcast). Packets with an unknown destination are dropped and counted.
//
// Handshake: pndng[i]=1 means the head of FIFO i is valid on lane i of
// D_pop. pop[i] is a one-cycle dequeue pulse, and the head is captured on
// the same edge that ends the pulse. push[i] is a one-cycle delivery pulse
// with the packet valid on lane i of D_push. Receivers cannot stall the bus.
module bs_arbtr_rr_bcast #(
  parameter int         pckg_sz   = 16,
  parameter int         drvrs     = 4,
  parameter logic [7:0] broadcast = 8'hFF,
  parameter bit         rr_mode   = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [drvrs-1:0]           pndng,
  input  logic [drvrs*pckg_sz-1:0]   D_pop,
  output logic [drvrs-1:0]           pop,
  output logic [drvrs-1:0]           push,
  output logic [drvrs*pckg_sz-1:0]   D_push,
  output logic                       bus_busy,
  output logic                       err,
  output logic [15:0]                drop_cnt,
  output logic [1:0]                 dbg_state_o
);

  localparam int IW = (drvrs > 1) ? $clog2(drvrs) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, DELIVER, GAP} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        w_q, w_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [pckg_sz-1:0]   pkt_q, pkt_d;
  logic [15:0]          drop_cnt_q, drop_cnt_d;

  logic [IW-1:0]        win;
  logic [pckg_sz-1:0]   head;
  logic [drvrs-1:0]     w_onehot;
  logic [7:0]           dest;
  logic [drvrs-1:0]     pop_c, push_c;
  logic                 err_c, busy_c;

  assign dest = pkt_q[pckg_sz-1 -: 8];

  // Pick the winner: circular search from ptr+1, or lowest pending index.
  always_comb begin
    logic          found;
    logic [IW-1:0] cand;
    win   = '0;
    found = 1'b0;
    cand  = '0;
    if (rr_mode) begin
      for (int k = 1; k <= drvrs; k++) begin
        cand = IW'((int'(ptr_q) + k) % drvrs);
        if (!found && pndng[cand]) begin
          win   = cand;
          found = 1'b1;
        end
      end
    end else begin
      for (int i = drvrs - 1; i >= 0; i--) begin
        if (pndng[i]) win = IW'(i);
      end
    end
  end

  // Select the granted driver's head packet and build its one-hot mask.
  always_comb begin
    head     = '0;
    w_onehot = '0;
    for (int i = 0; i < drvrs; i++) begin
      if (w_q == IW'(i)) begin
        head        = D_pop[i*pckg_sz +: pckg_sz];
        w_onehot[i] = 1'b1;
      end
    end
  end

  // Transfer sequencer: next state, bus strobes and drop accounting.
  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    ptr_d      = ptr_q;
    pkt_d      = pkt_q;
    drop_cnt_d = drop_cnt_q;
    pop_c      = '0;
    push_c     = '0;
    err_c      = 1'b0;
    busy_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|pndng) begin
          w_d     = win;
          state_d = GRANT;
        end
      end
      GRANT: begin
        busy_c  = 1'b1;
        pop_c   = w_onehot;
        pkt_d   = head;
        if (rr_mode) ptr_d = w_q;
        state_d = DELIVER;
      end
      DELIVER: begin
        busy_c = 1'b1;
        if (int'(dest) < drvrs) begin
          // Unicast; the source may address itself.
          for (int i = 0; i < drvrs; i++) push_c[i] = (int'(dest) == i);
        end else if (dest == broadcast) begin
          push_c = ~w_onehot;
        end else begin
          err_c = 1'b1;
          if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
        end
        state_d = GAP;
      end
      GAP: begin
        // Gives the popped FIFO a cycle to refresh pndng.
        busy_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      w_q        <= '0;
      ptr_q      <= IW'(drvrs - 1);
      pkt_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      w_q        <= w_d;
      ptr_q      <= ptr_d;
      pkt_q      <= pkt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Strobes are gated by reset so an aborted transfer emits nothing.
  assign pop         = pop_c & {drvrs{reset}};
  assign push        = push_c & {drvrs{reset}};
  assign err         = err_c & reset;
  assign bus_busy    = busy_c & reset;
  assign D_push      = {drvrs{pkt_q}};
  assign drop_cnt    = drop_cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bs_arbtr_rr_bcast.sv
// Directed bench for bs_arbtr_rr_bcast (drvrs=4, pckg_sz=16). A round-robin
// instance is scoreboarded on every push/err; a fixed-priority instance is
// exercised separately.
module tb_bs_arbtr_rr_bcast;

  localparam int P = 16;
  localparam int N = 4;
  localparam int W = N + P + 1;  // {push mask, data, err}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]   pndng, pop, push;
  logic [N*P-1:0] D_pop, D_push;
  logic           bus_busy, err;
  logic [15:0]    drop_cnt;
  logic [1:0]     dbg_state;

  logic [N-1:0]   pndng_f, pop_f, push_f;
  logic [N*P-1:0] D_pop_f, D_push_f;
  logic           bus_busy_f, err_f;
  logic [15:0]    drop_cnt_f;
  logic [1:0]     dbg_state_f;

  bs_arbtr_rr_bcast #(.pckg_sz(P), .drvrs(N), .broadcast(8'hFF), .rr_mode(1'b1)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop), .push(push),
    .D_push(D_push), .bus_busy(bus_busy), .err(err), .drop_cnt(drop_cnt),
    .dbg_state_o(dbg_state)
  );

  bs_arbtr_rr_bcast #(.pckg_sz(P), .drvrs(N), .broadcast(8'hFF), .rr_mode(1'b0)) dut_f (
    .clk(clk), .reset(reset), .pndng(pndng_f), .D_pop(D_pop_f), .pop(pop_f), .push(push_f),
    .D_push(D_push_f), .bus_busy(bus_busy_f), .err(err_f), .drop_cnt(drop_cnt_f),
    .dbg_state_o(dbg_state_f)
  );

  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;
  logic [W-1:0] exp_q[$];

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic set_lane(input int i, input logic [P-1:0] v);
    D_pop[i*P +: P] = v;
  endtask

  task automatic expect_out(input logic [N-1:0] pm, input logic [P-1:0] d, input logic e);
    exp_q.push_back({pm, d, e});
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    pndng   = '0;
    pndng_f = '0;
    tick();
    tick();
    chk("rst_strobes", {pop, push, bus_busy, err}, 64'd0);
    chk("rst_dpush", D_push, 64'd0);
    chk("rst_drop", drop_cnt, 64'd0);
    reset = 1'b1;
  endtask

  // One complete transfer from driver src; starts and ends in IDLE.
  task automatic xfer(input int src, input logic [P-1:0] pk, input logic [N-1:0] pm,
                      input logic e);
    logic [N-1:0] oh;
    oh      = '0;
    oh[src] = 1'b1;
    set_lane(src, pk);
    pndng = oh;
    if (pm != '0 || e) expect_out(pm, pk, e);
    tick();
    chk("grant_pop", pop, 64'(oh));
    chk("grant_busy_push_err", {bus_busy, push, err}, {58'd0, 1'b1, 5'd0});
    pndng = '0;
    tick();
    chk("deliver_pop_busy", {pop, bus_busy}, 64'd1);
    tick();
    chk("gap_strobes", {bus_busy, push, pop, err}, {54'd0, 1'b1, 9'd0});
    tick();
    chk("idle_busy", bus_busy, 64'd0);
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] mon_e;
  logic [P-1:0] mon_d;
  always @(negedge clk) begin
    if (mon_en && (push !== '0 || err !== 1'b0)) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL sb_unexpected: got push=%b err=%b want no output", push, err);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        mon_d = mon_e[P:1];
        for (int i = 0; i < N; i++)
          if (push[i] && D_push[i*P +: P] !== mon_e[P:1]) mon_d = D_push[i*P +: P];
        assert ({push, mon_d, err} === mon_e) else begin
          bad++;
          $error("FAIL sb_output: got %0h want %0h", {push, mon_d, err}, mon_e);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  int s, d, n, cnt1, cnt3;
  logic [7:0] pay;
  logic [N-1:0] pm;

  initial begin
    reset   = 1'b0;
    pndng   = '0;
    D_pop   = '0;
    pndng_f = '0;
    D_pop_f = '0;
    do_reset();
    mon_en = 1'b1;

    // unicast, broadcast, self-delivery
    xfer(1, 16'h03AB, 4'b1000, 1'b0);
    xfer(2, 16'hFF55, 4'b1011, 1'b0);
    xfer(3, 16'h0377, 4'b1000, 1'b0);
    xfer(0, 16'h02C4, 4'b0100, 1'b0);
    xfer(0, 16'hFF99, 4'b1110, 1'b0);
    for (int k = 0; k < 6; k++) begin
      s     = $urandom_range(0, N - 1);
      d     = $urandom_range(0, N - 1);
      pay   = 8'($urandom_range(0, 255));
      pm    = '0;
      pm[d] = 1'b1;
      xfer(s, {d[7:0], pay}, pm, 1'b0);
    end

    // invalid destinations and counter saturation
    xfer(0, 16'h0711, 4'b0000, 1'b1);
    chk("drop_cnt_1", drop_cnt, 64'd1);
    xfer(2, 16'h8012, 4'b0000, 1'b1);
    chk("drop_cnt_2", drop_cnt, 64'd2);
    force dut.drop_cnt_q = 16'hFFFD;
    #1;
    release dut.drop_cnt_q;
    chk("drop_cnt_preset", drop_cnt, 64'hFFFD);
    xfer(1, 16'h0400, 4'b0000, 1'b1);
    chk("drop_cnt_fffe", drop_cnt, 64'hFFFE);
    xfer(1, 16'h0401, 4'b0000, 1'b1);
    chk("drop_cnt_ffff", drop_cnt, 64'hFFFF);
    xfer(3, 16'h2000, 4'b0000, 1'b1);
    chk("drop_cnt_sat", drop_cnt, 64'hFFFF);

    // round-robin order and spacing
    do_reset();
    for (int i = 0; i < N; i++) set_lane(i, {8'h00, 8'hA0 + 8'(i)});
    for (int k = 0; k < 5; k++) expect_out(4'b0001, {8'h00, 8'hA0 + 8'(k % N)}, 1'b0);
    pndng = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (pop === '0 && n < 8);
      chk("rr_pop", pop, 64'(4'b0001 << (k % N)));
      chk("rr_spacing", n, (k == 0) ? 64'd1 : 64'd4);
    end
    pndng = '0;
    repeat (3) tick();
    chk("rr_idle_busy", bus_busy, 64'd0);

    // fixed priority: driver 1 starves driver 3
    set_lane(0, 16'h0000);
    D_pop_f = '0;
    pndng_f = 4'b1010;
    cnt1 = 0;
    cnt3 = 0;
    repeat (16) begin
      tick();
      if (pop_f[1]) cnt1++;
      if (pop_f[3]) cnt3++;
    end
    pndng_f = '0;
    chk("fp_drv1_grants", cnt1, 64'd4);
    chk("fp_drv3_grants", cnt3, 64'd0);
    chk("fp_rr_inst_idle", {pop, push}, 64'd0);

    // reset during DELIVER
    set_lane(0, 16'h0122);
    pndng = 4'b0001;
    tick();
    chk("mid_grant_pop", pop, 64'd1);
    pndng = '0;
    tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_no_push", {push, err}, 64'd0);
    tick();
    chk("mid_rst_strobes", {pop, push, bus_busy, err}, 64'd0);
    chk("mid_rst_dpush", D_push, 64'd0);
    chk("mid_rst_drop", drop_cnt, 64'd0);
    reset = 1'b1;
    for (int i = 0; i < N; i++) set_lane(i, {8'h00, 8'hB0 + 8'(i)});
    expect_out(4'b0001, 16'h00B0, 1'b0);
    pndng = 4'b1111;
    n = 0;
    do begin
      tick();
      n++;
    end while (pop === '0 && n < 8);
    chk("post_rst_pop", pop, 64'd1);
    chk("post_rst_latency", n, 64'd1);
    pndng = '0;
    repeat (3) tick();

    chk("sb_empty", exp_q.size(), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
